// File: rtl/hir_memref_if.sv
// HIR memref port bundle: one read port, one write port, plus responder status.
// The kernel side drives addresses/strobes (master); the memory side answers (slave).
interface hir_memref_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              ready;
  logic              err_oob;
  logic              err_busy;
  logic [31:0]       rd_count;
  logic [31:0]       wr_count;

  modport master (
    output rd_addr, rd_en, wr_addr, wr_en, wr_data,
    input  rd_data, rd_valid, ready, err_oob, err_busy, rd_count, wr_count
  );

  modport slave (
    input  rd_addr, rd_en, wr_addr, wr_en, wr_data,
    output rd_data, rd_valid, ready, err_oob, err_busy, rd_count, wr_count
  );
endinterface

// File: rtl/hir_memref_responder.sv
// Memref backing store: zero-init sweep after reset, RD_LATENCY-stage read pipeline, sticky errors, saturating counters.
// Optional macro HIR_MEMREF_BYPASS_EN selects write-first forwarding for same-cycle same-address read/write.
module hir_memref_responder #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 6,
  parameter int DEPTH      = 64,
  parameter int RD_LATENCY = 1
) (
  input logic         clk,
  input logic         rst,
  hir_memref_if.slave mem
);
  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, SERVE} state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  clr_ptr_q;
  logic              ready_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_W-1:0]     dat_q [RD_LATENCY];
  logic [DATA_W-1:0]     dat_d [RD_LATENCY];
  logic [31:0]           rd_count_q, rd_count_d;
  logic [31:0]           wr_count_q, wr_count_d;
  logic                  err_oob_q, err_oob_d;
  logic                  err_busy_q, err_busy_d;

  logic              serve;
  logic              rd_in_rng, wr_in_rng;
  logic              rd_acc, wr_acc;
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [DATA_W-1:0] rd_word;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdat;

  // Upper address bits only matter for the range check; indexing uses the low IDX_W bits.
  assign serve     = (state_q == SERVE);
  assign rd_in_rng = ({1'b0, mem.rd_addr} < DEPTH_C);
  assign wr_in_rng = ({1'b0, mem.wr_addr} < DEPTH_C);
  assign rd_acc    = serve & mem.rd_en;
  assign wr_acc    = serve & mem.wr_en;
  assign rd_idx    = mem.rd_addr[IDX_W-1:0];
  assign wr_idx    = mem.wr_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_ptr_q == LAST_IDX) begin
            state_q <= SERVE;
            ready_q <= 1'b1;
          end else begin
            clr_ptr_q <= clr_ptr_q + IDX_W'(1);
          end
        end
        default: ready_q <= 1'b1;
      endcase
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_widx = clr_ptr_q;
    mem_wdat = '0;
    if (!rst) begin
      if (!serve) begin
        mem_we = 1'b1;
      end else if (wr_acc && wr_in_rng) begin
        mem_we   = 1'b1;
        mem_widx = wr_idx;
        mem_wdat = mem.wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdat;
  end

  // Reads during CLEAR and out-of-range reads still produce a (zero) response.
  always_comb begin
    rd_word = '0;
    if (rd_acc && rd_in_rng) begin
      rd_word = mem_q[rd_idx];
`ifdef HIR_MEMREF_BYPASS_EN
      if (wr_acc && wr_in_rng && (mem.wr_addr == mem.rd_addr)) rd_word = mem.wr_data;
`endif
    end
  end

  // Each stage's data only moves with a valid token, so the output holds between responses.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = mem.rd_en;
    dat_d    = dat_q;
    if (mem.rd_en) dat_d[0] = rd_word;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
    end
  end

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (rd_acc && (rd_count_q != 32'hFFFF_FFFF)) rd_count_d = rd_count_q + 32'd1;
    if (wr_acc && (wr_count_q != 32'hFFFF_FFFF)) wr_count_d = wr_count_q + 32'd1;
    err_busy_d = err_busy_q | (!serve & (mem.rd_en | mem.wr_en));
    err_oob_d  = err_oob_q | (rd_acc & !rd_in_rng) | (wr_acc & !wr_in_rng);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat_q[i] <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
      err_oob_q  <= 1'b0;
      err_busy_q <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      dat_q      <= dat_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      err_oob_q  <= err_oob_d;
      err_busy_q <= err_busy_d;
    end
  end

  assign mem.rd_data  = dat_q[RD_LATENCY-1];
  assign mem.rd_valid = vld_q[RD_LATENCY-1];
  assign mem.ready    = ready_q;
  assign mem.err_oob  = err_oob_q;
  assign mem.err_busy = err_busy_q;
  assign mem.rd_count = rd_count_q;
  assign mem.wr_count = wr_count_q;
endmodule

// File: tb/tb_hir_memref_responder.sv
// Bench for hir_memref_responder: instance A (DEPTH 64, latency 1) and B (DEPTH 48, latency 3).
// Read responses are predicted into per-instance queues and checked for data and arrival cycle.
module tb_hir_memref_responder;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct {
    logic [31:0] dat;
    int          due;
  } exp_t;

  logic clk;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  hir_memref_if #(.DATA_W(32), .ADDR_W(6)) if_a ();
  hir_memref_if #(.DATA_W(32), .ADDR_W(6)) if_b ();

  hir_memref_responder #(.DATA_W(32), .ADDR_W(6), .DEPTH(64), .RD_LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst_a), .mem(if_a)
  );
  hir_memref_responder #(.DATA_W(32), .ADDR_W(6), .DEPTH(48), .RD_LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst(rst_b), .mem(if_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumers: every rd_valid must match the oldest prediction, on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (if_a.rd_valid === 1'b1) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_valid cyc=%0d got data=%h required no response", cyc, if_a.rd_data);
      end else begin
        e = q_a.pop_front();
        if (if_a.rd_data !== e.dat || cyc != e.due) begin
          errors++;
          $display("FAIL a_resp got data=%h cyc=%0d required data=%h cyc=%0d", if_a.rd_data, cyc, e.dat, e.due);
        end
      end
    end
    if (q_a.size() > 0 && q_a[0].due < cyc) begin
      checks++;
      errors++;
      e = q_a.pop_front();
      $display("FAIL a_missing_resp got none by cyc=%0d required data=%h at cyc=%0d", cyc, e.dat, e.due);
    end
    if (if_b.rd_valid === 1'b1) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_valid cyc=%0d got data=%h required no response", cyc, if_b.rd_data);
      end else begin
        e = q_b.pop_front();
        if (if_b.rd_data !== e.dat || cyc != e.due) begin
          errors++;
          $display("FAIL b_resp got data=%h cyc=%0d required data=%h cyc=%0d", if_b.rd_data, cyc, e.dat, e.due);
        end
      end
    end
    if (q_b.size() > 0 && q_b[0].due < cyc) begin
      checks++;
      errors++;
      e = q_b.pop_front();
      $display("FAIL b_missing_resp got none by cyc=%0d required data=%h at cyc=%0d", cyc, e.dat, e.due);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of port activity on instance b (0=A, 1=B) and predicts the read response.
  task automatic drive(input bit b, input bit rd, input logic [5:0] ra, input logic [31:0] exp,
                       input bit wr, input logic [5:0] wa, input logic [31:0] wd, input bit push);
    exp_t e;
    e.dat = exp;
    if (!b) begin
      if_a.rd_en = rd; if_a.rd_addr = ra; if_a.wr_en = wr; if_a.wr_addr = wa; if_a.wr_data = wd;
      e.due = cyc + LAT_A;
      if (rd && push) q_a.push_back(e);
    end else begin
      if_b.rd_en = rd; if_b.rd_addr = ra; if_b.wr_en = wr; if_b.wr_addr = wa; if_b.wr_data = wd;
      e.due = cyc + LAT_B;
      if (rd && push) q_b.push_back(e);
    end
    step();
  endtask

  task automatic rd(input bit b, input logic [5:0] a, input logic [31:0] exp);
    drive(b, 1'b1, a, exp, 1'b0, 6'd0, 32'd0, 1'b1);
  endtask

  task automatic wr(input bit b, input logic [5:0] a, input logic [31:0] d);
    drive(b, 1'b0, 6'd0, 32'd0, 1'b1, a, d, 1'b1);
  endtask

  task automatic idle(input bit b);
    drive(b, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q_a.size() + q_b.size()) != 0; i++) step();
    checks++;
    if (q_a.size() + q_b.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending responses required 0", q_a.size() + q_b.size());
    end
  endtask

  task automatic wait_ready_b();
    for (int i = 0; i < 200 && if_b.ready !== 1'b1; i++) step();
    checks++;
    if (if_b.ready !== 1'b1) begin
      errors++;
      $display("FAIL b_ready_timeout got ready=%b required 1", if_b.ready);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({if_a.rd_valid, if_a.ready, if_a.err_oob, if_a.err_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags_a got %b required 0000",
               {if_a.rd_valid, if_a.ready, if_a.err_oob, if_a.err_busy});
    end
    checks++;
    if ({if_b.rd_valid, if_b.ready, if_b.err_oob, if_b.err_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags_b got %b required 0000",
               {if_b.rd_valid, if_b.ready, if_b.err_oob, if_b.err_busy});
    end
    checks++;
    if ({if_a.rd_data, if_a.rd_count, if_a.wr_count} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data_counts_a got %h/%h/%h required 0/0/0", if_a.rd_data, if_a.rd_count, if_a.wr_count);
    end
    checks++;
    if ({if_b.rd_data, if_b.rd_count, if_b.wr_count} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data_counts_b got %h/%h/%h required 0/0/0", if_b.rd_data, if_b.rd_count, if_b.wr_count);
    end
  endtask

  task automatic test_init();
    int fa = -1, fb = -1, na = 0, nb = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (if_a.ready !== 1'b1) na++; else if (fa < 0) fa = i;
      if (if_b.ready !== 1'b1) nb++; else if (fb < 0) fb = i;
      step();
    end
    checks++;
    if (fa != 64 || na != 64) begin
      errors++;
      $display("FAIL init_ready_a got rise=%0d low=%0d required 64/64", fa, na);
    end
    checks++;
    if (fb != 48 || nb != 48) begin
      errors++;
      $display("FAIL init_ready_b got rise=%0d low=%0d required 48/48", fb, nb);
    end
    rd(0, 6'd0, 32'd0);
    rd(0, 6'd17, 32'd0);
    rd(0, 6'd63, 32'd0);
    idle(0);
    drain();
    checks++;
    if ({if_a.err_oob, if_a.err_busy, if_b.err_oob, if_b.err_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL init_errs got %b required 0000",
               {if_a.err_oob, if_a.err_busy, if_b.err_oob, if_b.err_busy});
    end
  endtask

  task automatic test_latency();
    logic [31:0] rc, wc;
    rc = if_a.rd_count;
    wc = if_a.wr_count;
    wr(0, 6'h2A, 32'hDEAD_BEEF);
    rd(0, 6'h2A, 32'hDEAD_BEEF);
    idle(0);
    wr(1, 6'h2A, 32'hDEAD_BEEF);
    rd(1, 6'h2A, 32'hDEAD_BEEF);
    idle(1);
    drain();
    checks++;
    if (if_a.wr_count !== wc + 32'd1 || if_a.rd_count !== rc + 32'd1) begin
      errors++;
      $display("FAIL latency_counts_a got wr=%0d rd=%0d required wr=%0d rd=%0d",
               if_a.wr_count, if_a.rd_count, wc + 32'd1, rc + 32'd1);
    end
    checks++;
    if (if_b.wr_count !== 32'd1 || if_b.rd_count !== 32'd1) begin
      errors++;
      $display("FAIL latency_counts_b got wr=%0d rd=%0d required wr=1 rd=1", if_b.wr_count, if_b.rd_count);
    end
  endtask

  task automatic test_burst(input bit b);
    for (int i = 0; i < 8; i++) wr(b, 6'(i), 32'(i * 3));
    for (int i = 0; i < 8; i++) rd(b, 6'(i), 32'(i * 3));
    idle(b);
    drain();
    step();
    checks++;
    if (!b && (if_a.rd_valid !== 1'b0 || if_a.rd_data !== 32'd21)) begin
      errors++;
      $display("FAIL burst_hold_a got valid=%b data=%0d required valid=0 data=21", if_a.rd_valid, if_a.rd_data);
    end
    if (b && (if_b.rd_valid !== 1'b0 || if_b.rd_data !== 32'd21)) begin
      errors++;
      $display("FAIL burst_hold_b got valid=%b data=%0d required valid=0 data=21", if_b.rd_valid, if_b.rd_data);
    end
  endtask

  task automatic test_collision(input bit b);
    logic [31:0] exp_col;
`ifdef HIR_MEMREF_BYPASS_EN
    exp_col = 32'h22;
`else
    exp_col = 32'h11;
`endif
    wr(b, 6'd5, 32'h11);
    drive(b, 1'b1, 6'd5, exp_col, 1'b1, 6'd5, 32'h22, 1'b1);
    rd(b, 6'd5, 32'h22);
    idle(b);
    drain();
  endtask

  task automatic test_errors();
    logic [31:0] rc, wc;
    wr(1, 6'd18, 32'hAAAA_0018);
    wr(1, 6'd2, 32'hBBBB_0002);
    idle(1);
    rc = if_b.rd_count;
    wc = if_b.wr_count;
    checks++;
    if (if_b.err_oob !== 1'b0) begin
      errors++;
      $display("FAIL oob_pre got err_oob=%b required 0", if_b.err_oob);
    end
    wr(1, 6'd50, 32'hCAFE_F00D);
    idle(1);
    checks++;
    if (if_b.err_oob !== 1'b1 || if_b.err_busy !== 1'b0) begin
      errors++;
      $display("FAIL oob_write got oob=%b busy=%b required oob=1 busy=0", if_b.err_oob, if_b.err_busy);
    end
    rd(1, 6'd50, 32'd0);
    rd(1, 6'd18, 32'hAAAA_0018);
    rd(1, 6'd2, 32'hBBBB_0002);
    rd(1, 6'd48, 32'd0);
    idle(1);
    drain();
    checks++;
    if (if_b.wr_count !== wc + 32'd1 || if_b.rd_count !== rc + 32'd4) begin
      errors++;
      $display("FAIL oob_counts got wr=%0d rd=%0d required wr=%0d rd=%0d",
               if_b.wr_count, if_b.rd_count, wc + 32'd1, rc + 32'd4);
    end
    // Access during the clear sweep, aimed at an address the sweep has already passed.
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    for (int i = 0; i < 10; i++) step();
    drive(1, 1'b1, 6'd3, 32'd0, 1'b1, 6'd3, 32'h77, 1'b1);
    idle(1);
    wait_ready_b();
    drain();
    checks++;
    if (if_b.err_busy !== 1'b1 || if_b.err_oob !== 1'b0) begin
      errors++;
      $display("FAIL busy_flags got busy=%b oob=%b required busy=1 oob=0", if_b.err_busy, if_b.err_oob);
    end
    checks++;
    if (if_b.rd_count !== 32'd0 || if_b.wr_count !== 32'd0) begin
      errors++;
      $display("FAIL busy_counts got rd=%0d wr=%0d required 0/0", if_b.rd_count, if_b.wr_count);
    end
    rd(1, 6'd3, 32'd0);
    idle(1);
    drain();
  endtask

  task automatic test_midop_reset();
    int pulses = 0;
    wr(1, 6'd9, 32'h99);
    drive(1, 1'b1, 6'd9, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0);
    if_b.rd_en = 1'b0;
    rst_b = 1'b1;
    step();
    checks++;
    if (if_b.rd_valid !== 1'b0 || if_b.rd_data !== 32'd0 || if_b.ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state got valid=%b data=%h ready=%b required 0/0/0",
               if_b.rd_valid, if_b.rd_data, if_b.ready);
    end
    rst_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (if_b.rd_valid === 1'b1) pulses++;
      step();
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midrst_pulses got %0d required 0", pulses);
    end
    wait_ready_b();
    checks++;
    if (if_b.rd_count !== 32'd0 || if_b.wr_count !== 32'd0 || if_b.err_busy !== 1'b0 || if_b.err_oob !== 1'b0) begin
      errors++;
      $display("FAIL midrst_counts got rd=%0d wr=%0d busy=%b oob=%b required 0/0/0/0",
               if_b.rd_count, if_b.wr_count, if_b.err_busy, if_b.err_oob);
    end
    rd(1, 6'd9, 32'd0);
    rd(1, 6'h2A, 32'd0);
    idle(1);
    drain();
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.rd_en = 1'b0; if_a.rd_addr = '0; if_a.wr_en = 1'b0; if_a.wr_addr = '0; if_a.wr_data = '0;
    if_b.rd_en = 1'b0; if_b.rd_addr = '0; if_b.wr_en = 1'b0; if_b.wr_addr = '0; if_b.wr_data = '0;
    step();
    step();
    test_reset();
    test_init();
    test_latency();
    test_burst(1'b0);
    test_burst(1'b1);
    test_collision(1'b0);
    test_collision(1'b1);
    test_errors();
    test_midop_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hir_memref_responder.md
Name: hir_memref_responder

Overview:
- Memory-side responder for the HIR memref port protocol. It sits on the other end of the read (addr/rd_en/rd_data) and write (addr/wr_en/wr_data) ports that compiled HIR kernels drive.
- Serves one read port and one write port against an internal DEPTH-word array, with a fixed read latency.
- Zero-initialises the array after reset, flags protocol violations, and counts accesses. Used as the on-chip backing store and as the bench memory for generated kernels.

Parameters:
- DATA_W, 32, word width in bits.
- ADDR_W, 6, address width; the address is a packed multi-dim index, e.g. {row, col}.
- DEPTH, 64, number of valid words; addresses >= DEPTH are out of range. Must satisfy DEPTH <= 2**ADDR_W.
- RD_LATENCY, 1, cycles from rd_en to rd_data valid; legal values 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  ADDR_W  read address; sampled when rd_en=1.
- rd_en  in  1  read request.
- rd_data  out  DATA_W  read data, valid exactly RD_LATENCY cycles after rd_en.
- rd_valid  out  1  high in the cycle rd_data carries the response.
- wr_addr  in  ADDR_W  write address.
- wr_en  in  1  write strobe.
- wr_data  in  DATA_W  write data, sampled with wr_en.
- ready  out  1  high once initialisation is complete.
- err_oob  out  1  sticky: an out-of-range access occurred.
- err_busy  out  1  sticky: an access arrived while ready=0.
- rd_count  out  32  accepted reads, saturating.
- wr_count  out  32  accepted writes, saturating.

Behaviour:
- Reset state (rst=1 at a clk edge):
  - rd_data=0, rd_valid=0, ready=0, err_oob=0, err_busy=0, rd_count=0, wr_count=0.
  - Read pipeline flushed; clear pointer set to 0; FSM enters CLEAR.
- FSM states: CLEAR and SERVE.
  - CLEAR: writes 0 to word[ptr] each cycle and increments ptr; moves to SERVE after ptr=DEPTH-1 is written.
  - ready rises in the cycle after the last clear write, i.e. DEPTH cycles after the first cycle with rst=0.
- Accesses in CLEAR: rd_en or wr_en sets err_busy. The write is dropped; the read returns rd_data=0 with rd_valid after RD_LATENCY. Counters are not incremented.
- Reads in SERVE:
  - rd_en=1 with rd_addr<DEPTH: array read at the request edge; data delayed through a RD_LATENCY-stage pipeline.
  - rd_valid/rd_data present at request cycle + RD_LATENCY, for one cycle.
  - Back-to-back reads are fully pipelined, one response per cycle.
  - rd_data holds its last value when rd_valid=0.
- Writes in SERVE: wr_en=1 with wr_addr<DEPTH updates word[wr_addr] at that edge; data is visible to reads issued in a later cycle.
- Out of range (addr >= DEPTH):
  - Sets err_oob.
  - A write is dropped.
  - A read returns 0 with normal rd_valid timing.
  - Counters still increment.
- Same-cycle rd_en and wr_en:
  - Both are accepted; the ports are independent.
  - If the addresses are equal, the read returns the old (pre-write) data: read-first.
- Counters: +1 per accepted access in SERVE; saturate at 32'hFFFF_FFFF without wrapping.
- Sticky errors clear only on rst.
- Reset mid-operation:
  - In-flight read responses are discarded; rd_valid=0 from the next cycle.
  - The array is re-cleared; all prior contents are lost.
- Address bits above clog2(DEPTH) take part in the range check only.

Optional Feature:
- Macro HIR_MEMREF_BYPASS_EN.
- Defined: write-first forwarding. A same-cycle rd_en/wr_en to an equal, in-range address returns wr_data for that read.
- Undefined: read-first behaviour as above. No bypass mux is synthesised.

Test Plan:
- Init: release rst, DEPTH=64 -> ready=0 for 64 cycles, ready=1 on cycle 64; reads of addrs 0, 17 and 63 return 0; err flags stay 0.
- Write/read latency: write 0xDEADBEEF to addr 0x2A, then read 0x2A the next cycle with RD_LATENCY=1 and again with RD_LATENCY=3 -> rd_valid and rd_data=0xDEADBEEF exactly 1 (resp. 3) cycles after rd_en. wr_count=1, rd_count=1.
- Pipelined burst: after writing addr 0..7 with the value addr*3, read 8 consecutive cycles -> 8 consecutive rd_valid pulses with data 0,3,6,...,21 in order.
- Collision: addr 5 holds 0x11; same cycle rd_en+wr_en on addr 5 with wr_data 0x22 -> response 0x11 (0x22 with HIR_MEMREF_BYPASS_EN); a later read returns 0x22.
- Errors: with DEPTH=48, write addr 50 -> err_oob=1 and no array change; a read of addr 50 returns 0. Any access during CLEAR -> err_busy=1 and counters unchanged.
- Mid-op reset: issue a read with RD_LATENCY=3, assert rst one cycle later -> no rd_valid pulse; the array reads 0 after the new ready; counters are 0.
